// File: rtl/fury_pkg.sv
// Shared steering, route-action, state and drive-level definitions for the
// line-following robot. Also used by the direction decoder.
package fury_pkg;

  // Steering codes: upper 2 bits side (00 proceed, 10 right, 01 left, 11 stop),
  // lower 2 bits magnitude (01 veer, 10 hard, 11 ninety).
  localparam logic [3:0] PROCEED      = 4'b0000;
  localparam logic [3:0] VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] VEER_LEFT    = 4'b0101;
  localparam logic [3:0] HARD_LEFT    = 4'b0110;
  localparam logic [3:0] NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] STOP         = 4'b1111;

  // Route entry actions.
  localparam logic [1:0] ACT_STRAIGHT = 2'b00;
  localparam logic [1:0] ACT_LEFT     = 2'b01;
  localparam logic [1:0] ACT_RIGHT    = 2'b10;
  localparam logic [1:0] ACT_END      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_DWELL  = 3'd2,
    ST_TURN   = 3'd3,
    ST_CROSS  = 3'd4,
    ST_DONE   = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_HALF = 2'd1,
    LVL_FULL = 2'd2
  } level_e;

  // Per-wheel drive request: PWM level plus direction (1 = forward).
  typedef struct packed {
    level_e lvl;
    logic   fwd;
  } wheel_drive_t;

  function automatic wheel_drive_t wheel_drive(input level_e lvl, input logic fwd);
    wheel_drive_t w;
    w.lvl = lvl;
    w.fwd = fwd;
    return w;
  endfunction

  // Map a drive level onto the PWM gate bits.
  function automatic logic level_gate(input level_e lvl, input logic full, input logic half);
    logic g;
    case (lvl)
      LVL_FULL: g = full;
      LVL_HALF: g = half;
      default:  g = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/route_sequencer_pwm_gen.sv
// Free-running PWM period counter producing full and half duty gate bits.
module pwm_gen #(
  parameter int unsigned PWM_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic full,
  output logic half
);

  localparam int unsigned CW = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;

  logic [CW-1:0] cnt_q;

  // Period counter 0..PWM_PERIOD-1, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(PWM_PERIOD - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign full = 1'b1;
  assign half = (cnt_q < CW'(PWM_PERIOD / 2));

endmodule

// File: rtl/route_sequencer.sv
// Route sequencer: follows the line decoder's steering in FOLLOW, and at each
// intersection dwells, then executes the next programmed route entry.
// Optional feature: define ROUTE_LOOP_EN to make the end entry restart the
// route (index back to 0, drive straight across) instead of entering DONE.
module route_sequencer
  import fury_pkg::*;
#(
  parameter int unsigned ROUTE_LEN    = 8,
  parameter int unsigned PWM_PERIOD   = 1000,
  parameter int unsigned DWELL_CYCLES = 5_000_000,
  parameter int unsigned TURN_CYCLES  = 20_000_000,
  parameter int unsigned CROSS_CYCLES = 10_000_000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      halt,
  input  logic [3:0]                                dir_code,
  input  logic [2*ROUTE_LEN-1:0]                    route,
  output logic                                      mtr_l_en,
  output logic                                      mtr_r_en,
  output logic                                      mtr_l_fwd,
  output logic                                      mtr_r_fwd,
  output logic [((ROUTE_LEN > 1) ? $clog2(ROUTE_LEN) : 1)-1:0] route_idx,
  output logic [2:0]                                state_o,
  output logic                                      done
);

  localparam int unsigned IDX_W   = (ROUTE_LEN > 1) ? $clog2(ROUTE_LEN) : 1;
  localparam int unsigned MAX_A   = (DWELL_CYCLES > TURN_CYCLES) ? DWELL_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > CROSS_CYCLES) ? MAX_A : CROSS_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic             stop_q;
  logic             turn_left_q, turn_left_d;
  logic             stop_now, isect;
  logic [1:0]       act;
  logic             pwm_full, pwm_half;
  wheel_drive_t     drive_l, drive_r;

  pwm_gen #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm (
    .clk  (clk),
    .rst  (rst),
    .full (pwm_full),
    .half (pwm_half)
  );

  // Intersection = rising edge of the STOP code; tracked in every state.
  assign stop_now = (dir_code == STOP);
  assign isect    = stop_now & ~stop_q;
  assign act      = route[2*int'(idx_q) +: 2];
  assign idx_inc  = (idx_q == IDX_W'(ROUTE_LEN - 1)) ? '0 : idx_q + IDX_W'(1);

  // Next-state, route index and turn direction.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    turn_left_d = turn_left_q;
    if (halt) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_FOLLOW;
        ST_FOLLOW: if (isect) state_d = ST_DWELL;
        ST_DWELL: begin
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            idx_d = idx_inc;
            case (act)
              ACT_STRAIGHT: state_d = ST_CROSS;
              ACT_LEFT: begin
                state_d     = ST_TURN;
                turn_left_d = 1'b1;
              end
              ACT_RIGHT: begin
                state_d     = ST_TURN;
                turn_left_d = 1'b0;
              end
              default: begin
`ifdef ROUTE_LOOP_EN
                idx_d   = '0;
                state_d = ST_CROSS;
`else
                state_d = ST_DONE;
`endif
              end
            endcase
          end
        end
        ST_TURN:  if (cnt_q == CNT_W'(TURN_CYCLES - 1))  state_d = ST_FOLLOW;
        ST_CROSS: if (cnt_q == CNT_W'(CROSS_CYCLES - 1)) state_d = ST_FOLLOW;
        ST_DONE:  if (start) state_d = ST_FOLLOW;
        ST_HALT:  if (start) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Wheel drive request for the state being entered; decoder owns FOLLOW.
  always_comb begin
    drive_l = wheel_drive(LVL_OFF, 1'b1);
    drive_r = wheel_drive(LVL_OFF, 1'b1);
    case (state_d)
      ST_FOLLOW: begin
        case (dir_code)
          PROCEED: begin
            drive_l = wheel_drive(LVL_FULL, 1'b1);
            drive_r = wheel_drive(LVL_FULL, 1'b1);
          end
          VEER_RIGHT: begin
            drive_l = wheel_drive(LVL_FULL, 1'b1);
            drive_r = wheel_drive(LVL_HALF, 1'b1);
          end
          HARD_RIGHT: begin
            drive_l = wheel_drive(LVL_FULL, 1'b1);
          end
          NINETY_RIGHT: begin
            drive_l = wheel_drive(LVL_FULL, 1'b1);
            drive_r = wheel_drive(LVL_FULL, 1'b0);
          end
          VEER_LEFT: begin
            drive_l = wheel_drive(LVL_HALF, 1'b1);
            drive_r = wheel_drive(LVL_FULL, 1'b1);
          end
          HARD_LEFT: begin
            drive_r = wheel_drive(LVL_FULL, 1'b1);
          end
          NINETY_LEFT: begin
            drive_l = wheel_drive(LVL_FULL, 1'b0);
            drive_r = wheel_drive(LVL_FULL, 1'b1);
          end
          default: ;
        endcase
      end
      ST_TURN: begin
        drive_l = wheel_drive(LVL_FULL, ~turn_left_d);
        drive_r = wheel_drive(LVL_FULL, turn_left_d);
      end
      ST_CROSS: begin
        drive_l = wheel_drive(LVL_FULL, 1'b1);
        drive_r = wheel_drive(LVL_FULL, 1'b1);
      end
      default: ;
    endcase
  end

  // State, phase counter, index and registered motor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      turn_left_q <= 1'b0;
      mtr_l_en    <= 1'b0;
      mtr_r_en    <= 1'b0;
      mtr_l_fwd   <= 1'b1;
      mtr_r_fwd   <= 1'b1;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stop_q      <= stop_now;
      turn_left_q <= turn_left_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      mtr_l_en  <= level_gate(drive_l.lvl, pwm_full, pwm_half);
      mtr_r_en  <= level_gate(drive_r.lvl, pwm_full, pwm_half);
      mtr_l_fwd <= drive_l.fwd;
      mtr_r_fwd <= drive_r.fwd;
      done      <= (state_d == ST_DONE);
    end
  end

  assign route_idx = idx_q;
  assign state_o   = 3'(state_q);

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_route_sequencer;

  localparam int unsigned RL = 4;
  localparam int unsigned PP = 8;
  localparam int unsigned DW = 5;
  localparam int unsigned TC = 7;
  localparam int unsigned CC = 6;

  logic            clk = 1'b0;
  logic            rst, start, halt;
  logic [3:0]      dir_code;
  logic [2*RL-1:0] route;
  logic            mtr_l_en, mtr_r_en, mtr_l_fwd, mtr_r_fwd, done;
  logic [1:0]      route_idx;
  logic [2:0]      state_o;

  always #5 clk = ~clk;

  route_sequencer #(
    .ROUTE_LEN   (RL),
    .PWM_PERIOD  (PP),
    .DWELL_CYCLES(DW),
    .TURN_CYCLES (TC),
    .CROSS_CYCLES(CC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .halt     (halt),
    .dir_code (dir_code),
    .route    (route),
    .mtr_l_en (mtr_l_en),
    .mtr_r_en (mtr_r_en),
    .mtr_l_fwd(mtr_l_fwd),
    .mtr_r_fwd(mtr_r_fwd),
    .route_idx(route_idx),
    .state_o  (state_o),
    .done     (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: mission phase, cycles spent in it, route position.
  int m_state, m_time, m_idx, m_pwm;
  bit m_prev, m_left;
  int e_en_l, e_en_r, e_fwd_l, e_fwd_r, e_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Steering code to (level, forward) per wheel; level 0 off, 1 half, 2 full.
  task automatic follow_map(input int code, output int ll, output int rl, output int lf, output int rf);
    int side, mag, inner_l, inner_f;
    ll = 0; rl = 0; lf = 1; rf = 1;
    side = code / 4;
    mag  = code % 4;
    if (code == 0) begin
      ll = 2; rl = 2;
    end else if ((side == 1 || side == 2) && mag != 0) begin
      inner_l = (mag == 1) ? 1 : (mag == 2) ? 0 : 2;
      inner_f = (mag == 3) ? 0 : 1;
      if (side == 2) begin rl = inner_l; rf = inner_f; ll = 2; end
      else           begin ll = inner_l; lf = inner_f; rl = 2; end
    end
  endtask

  task automatic model_step();
    int ns, a, ll, rl, lf, rf;
    bit ev, half_on;
    if (rst) begin
      m_state = 0; m_time = 0; m_idx = 0; m_pwm = 0; m_prev = 0; m_left = 0;
      e_en_l = 0; e_en_r = 0; e_fwd_l = 1; e_fwd_r = 1; e_done = 0;
      return;
    end
    ev = (dir_code == 4'hF) && !m_prev;
    m_prev = (dir_code == 4'hF);
    ns = m_state;
    if (halt) ns = 6;
    else begin
      case (m_state)
        0: if (start) ns = 1;
        1: if (ev) ns = 2;
        2: if (m_time + 1 == DW) begin
             a = int'((route >> (2 * m_idx)) & 8'h3);
             m_idx = (m_idx + 1) % RL;
             if (a == 0) ns = 4;
             else if (a == 3) begin
`ifdef ROUTE_LOOP_EN
               m_idx = 0; ns = 4;
`else
               ns = 5;
`endif
             end else begin
               ns = 3; m_left = (a == 1);
             end
           end
        3: if (m_time + 1 == TC) ns = 1;
        4: if (m_time + 1 == CC) ns = 1;
        5: if (start) ns = 1;
        6: if (start) ns = 0;
        default: ns = 0;
      endcase
    end
    m_time  = (ns != m_state) ? 0 : m_time + 1;
    m_state = ns;
    ll = 0; rl = 0; lf = 1; rf = 1;
    if (ns == 1) follow_map(int'(dir_code), ll, rl, lf, rf);
    else if (ns == 3) begin ll = 2; rl = 2; lf = m_left ? 0 : 1; rf = m_left ? 1 : 0; end
    else if (ns == 4) begin ll = 2; rl = 2; end
    half_on = (m_pwm < PP / 2);
    e_en_l  = (ll == 2 || (ll == 1 && half_on)) ? 1 : 0;
    e_en_r  = (rl == 2 || (rl == 1 && half_on)) ? 1 : 0;
    e_fwd_l = lf; e_fwd_r = rf;
    e_done  = (ns == 5) ? 1 : 0;
    m_pwm   = (m_pwm + 1) % PP;
  endtask

  // Advance one clock with current inputs and compare every output.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("state",  32'(state_o),   32'(m_state));
    check("idx",    32'(route_idx), 32'(m_idx));
    check("en",     32'({mtr_l_en, mtr_r_en}),   32'(e_en_l * 2 + e_en_r));
    check("fwd",    32'({mtr_l_fwd, mtr_r_fwd}), 32'(e_fwd_l * 2 + e_fwd_r));
    check("done",   32'(done),      32'(e_done));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hi_cnt, saved_idx, exp_idx;
    rst = 1; start = 0; halt = 0; dir_code = 4'h0;
    route = {2'b10, 2'b00, 2'b11, 2'b01};
    steps(3);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_fwd", 32'({mtr_l_fwd, mtr_r_fwd}), 32'd3);

    // Start and drive straight.
    rst = 0; start = 1; dir_code = 4'h0;
    step();
    check("start_follow", 32'(state_o), 32'd1);
    start = 0;
    steps(2);
    check("proceed_en", 32'({mtr_l_en, mtr_r_en}), 32'd3);

    // Veer right: right wheel at half duty.
    dir_code = 4'b1001;
    steps(PP);
    hi_cnt = 0;
    for (int i = 0; i < int'(PP); i++) begin
      step();
      if (mtr_r_en) hi_cnt++;
      check("veer_l_en", 32'(mtr_l_en), 32'd1);
    end
    check("veer_r_duty", 32'(hi_cnt), 32'(PP / 2));

    // First intersection: entry 0 is left.
    dir_code = 4'hF;
    step();
    check("isect_dwell", 32'(state_o), 32'd2);
    dir_code = 4'h0;
    steps(DW);
    check("turn_fwd", 32'({mtr_l_fwd, mtr_r_fwd}), 32'b01);
    steps(TC);
    check("after_turn", 32'(state_o), 32'd1);
    check("after_turn_idx", 32'(route_idx), 32'd1);

    // Second intersection: entry 1 is end.
    dir_code = 4'hF;
    step();
    dir_code = 4'h0;
    steps(DW);
`ifdef ROUTE_LOOP_EN
    check("end_loop_state", 32'(state_o), 32'd4);
    check("end_loop_idx", 32'(route_idx), 32'd0);
    steps(CC);
`else
    check("end_done", 32'(done), 32'd1);
    check("end_motors", 32'({mtr_l_en, mtr_r_en}), 32'd0);
    steps(3);
    start = 1;
    step();
    start = 0;
`endif
    steps(2);

    // Halt in the middle of a turn.
    route = {RL{2'b01}};
    dir_code = 4'hF;
    step();
    dir_code = 4'h0;
    steps(DW + 3);
    saved_idx = m_idx;
    halt = 1;
    step();
    check("halt_state", 32'(state_o), 32'd6);
    check("halt_motors", 32'({mtr_l_en, mtr_r_en}), 32'd0);
    halt = 0;
    steps(2);
    start = 1;
    step();
    check("halt_idle", 32'(state_o), 32'd0);
    check("halt_idx_kept", 32'(route_idx), 32'(saved_idx));
    step();
    start = 0;

    // STOP held for three dwell periods: one event only.
    saved_idx = m_idx;
    exp_idx = (saved_idx + 1) % RL;
    dir_code = 4'hF;
    steps(3 * DW + TC + 4);
    check("held_stop_idx", 32'(route_idx), 32'(exp_idx));
    check("held_stop_state", 32'(state_o), 32'd1);
    dir_code = 4'h0;
    steps(2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) route = (2*RL)'($urandom);
      rst   = ($urandom_range(0, 799) == 0);
      halt  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0)
        dir_code = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/route_sequencer.md
# route_sequencer

Mission-level controller sitting between the line-following direction decoder and the motor driver pins. In FOLLOW it translates the decoder's 4-bit steering code into per-wheel enable/direction with PWM. On each intersection (decoder code transitions to STOP) it pauses, then executes the next entry of a programmed route: straight, left, right or end. Motor pins are owned by exactly one source at a time: the decoder in FOLLOW, the sequencer in all other states.

## Interface
- `ROUTE_LEN`, 8: number of 2-bit route entries.
- `PWM_PERIOD`, 1000: PWM period in clk cycles.
- `DWELL_CYCLES`, 5_000_000: stopped pause at each intersection.
- `TURN_CYCLES`, 20_000_000: spin duration for a left or right entry.
- `CROSS_CYCLES`, 10_000_000: blind straight drive for a straight entry.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: level. Leaves IDLE/DONE/HALT.
- `halt` in 1: level. Emergency stop, wins over everything except `rst`.
- `dir_code` in 4: steering code. Upper 2 bits: 00 proceed, 10 right, 01 left, 11 stop. Lower 2 bits: 01 veer, 10 hard, 11 ninety.
- `route` in 2*ROUTE_LEN: entry i at bits [2i+1:2i]. 00 straight, 01 left, 10 right, 11 end.
- `mtr_l_en`, `mtr_r_en` out 1: wheel enable, PWM-gated.
- `mtr_l_fwd`, `mtr_r_fwd` out 1: 1 = forward, 0 = reverse.
- `route_idx` out clog2(ROUTE_LEN): next entry to execute.
- `state_o` out 3: current state encoding.
- `done` out 1: high in DONE.

## Operation
- States and encodings:
  - IDLE 0
  - FOLLOW 1
  - DWELL 2
  - TURN 3
  - CROSS 4
  - DONE 5
  - HALT 6
- Transitions:
  - IDLE → FOLLOW on `start`.
  - FOLLOW → DWELL on an intersection event, defined as `dir_code`==4'b1111 this cycle and not last cycle. Load the dwell counter.
  - DWELL → act on `route[route_idx]` when the counter reaches DWELL_CYCLES-1:
    - 00 → CROSS
    - 01 or 10 → TURN
    - 11 → DONE
    - In every case `route_idx` increments, including on 11.
  - TURN/CROSS → FOLLOW after TURN_CYCLES / CROSS_CYCLES.
  - DONE → FOLLOW on `start`; `route_idx` is not reset.
  - HALT → IDLE on `start`. `route_idx` is preserved; `rst` is the only way to clear it.
  - Any state except HALT → HALT while `halt`=1.
- FOLLOW drive mapping (L, R):
  - proceed: full, full
  - veer right: full, half
  - hard right: full, off
  - ninety right: full forward, full reverse
  - Left codes mirror the right codes.
  - stop, or any undefined code: off, off
- Drive in the other states:
  - TURN left: L full reverse, R full forward. TURN right is the mirror.
  - CROSS: both full forward.
  - IDLE, DWELL, DONE, HALT: both off, fwd=1.
- PWM levels, with the counter running 0..PWM_PERIOD-1 and wrapping:
  - full: en=1
  - half: en = (counter < PWM_PERIOD/2)
  - off: en=0
- Counters and widths:
  - Phase counter width covers max(DWELL, TURN, CROSS).
  - It is cleared on every state entry.
  - It never wraps inside a state.
- `route_idx` wraps from ROUTE_LEN-1 to 0.
- Simultaneous events:
  - `halt` and `start` together: HALT.
  - `halt` and an intersection event together: HALT, no index increment.
  - A STOP code in DWELL, TURN or CROSS is ignored; the edge detector still tracks it.

## Timing
- All outputs are registered. `dir_code` change → motor pins change 1 cycle later (PWM phase permitting).
- Intersection event at cycle n → state_o=DWELL at n+1.
- DWELL lasts exactly DWELL_CYCLES cycles. TURN and CROSS likewise.
- Reset values:
  - state IDLE
  - all `mtr_*_en`=0, all `mtr_*_fwd`=1
  - `route_idx`=0, `done`=0
  - PWM counter 0, edge register 0
- `rst` mid-turn: the next cycle is IDLE with motors off.

## Configuration
- `ROUTE_LOOP_EN` defined: entry 11 does not go to DONE. `route_idx` is set to 0 and the state goes to CROSS, so the route repeats indefinitely.
- `ROUTE_LOOP_EN` undefined: entry 11 → DONE as above.

## Structure
- Shared package `fury_pkg` holds:
  - steering code constants (PROCEED, VEER/HARD/NINETY_LEFT/RIGHT, STOP)
  - route action constants
  - the state enum
- Those constants are also reused by the direction decoder.
- One sub-module, `pwm_gen`: free-running period counter, outputs `full`/`half` gate bits.
- The top-level FSM selects per wheel among off, half and full.

## Test plan
- Reset, then `start`, `dir_code`=0000 → state FOLLOW; both en=1 and fwd=1 from the next cycle.
- `dir_code`=1001 in FOLLOW → L en=1; R en high for PWM_PERIOD/2 cycles of each period.
- route[1:0]=01, STOP edge → DWELL for DWELL_CYCLES, then TURN with L fwd=0/R fwd=1, then FOLLOW; `route_idx`=1.
- route entry 11 → `done`=1, motors off. With `ROUTE_LOOP_EN`: `route_idx`=0 and state CROSS instead.
- `halt` asserted in the middle of TURN → HALT next cycle, motors off. `start` → IDLE with `route_idx` unchanged.
- STOP held continuously for 3 DWELL periods → exactly one intersection event and one index increment.
